// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for the byte-addressable data memory.
// Build macro MISALIGN_TRAP_EN: misaligned word/half requests return rsp_err instead of being aligned down.
module lsu_mem_master #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mRD,
  output logic              mWR,
  output logic              Byte,
  output logic              SigCtr,
  output logic [ADDR_W-1:0] DAddr,
  output logic [31:0]       DataIn,
  input  logic [31:0]       DataOut
);

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wcnt;
  logic              accept, ld_done;
  logic              req_word, req_half, misalign;
  logic [ADDR_W-1:0] addr_in;

  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic              we_p0, sgn_p0, err_p0;
  logic [31:0]       wdata_p0;
  logic              is_word_p0, is_half_p0, is_byte_p0;
  logic [31:0]       rd0_p1;
  logic [7:0]        rd1_p1;

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    hs = h;
    ext_half = sgn ? {{16{hs[15]}}, h} : {16'b0, h};
  endfunction

  // Halfwords are assembled from two byte reads; bytes and words come back already formed.
  function automatic logic [31:0] form_load(input logic [1:0] size, input logic sgn,
                                            input logic [31:0] w0, input logic [7:0] b1);
    if (size == 2'b01) form_load = ext_half({b1, w0[7:0]}, sgn);
    else               form_load = w0;
  endfunction

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = req_valid && req_ready;
  assign req_word   = req_size[1];
  assign req_half   = (req_size == 2'b01);
  assign is_word_p0 = size_p0[1];
  assign is_half_p0 = (size_p0 == 2'b01);
  assign is_byte_p0 = (size_p0 == 2'b00);
  assign ld_done    = (wcnt == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
  logic rsp_err_q;
  assign misalign = (req_word && (req_addr[1:0] != 2'b00)) || (req_half && req_addr[0]);
  assign addr_in  = req_addr;
  assign rsp_err  = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p0    <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) err_p0 <= misalign;
      rsp_err_q <= (state == RESP) && err_p0;
    end
  end
`else
  assign misalign = 1'b0;
  assign err_p0   = 1'b0;
  assign rsp_err  = 1'b0;
  assign addr_in  = req_word ? {req_addr[ADDR_W-1:2], 2'b00} :
                    req_half ? {req_addr[ADDR_W-1:1], 1'b0}  : req_addr;
`endif

  // Memory strobes are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    state_nxt = state;
    mRD       = 1'b0;
    mWR       = 1'b0;
    Byte      = 1'b0;
    SigCtr    = 1'b0;
    DAddr     = '0;
    DataIn    = '0;
    case (state)
      IDLE: if (accept) state_nxt = misalign ? RESP : ACC0;
      ACC0: begin
        DAddr  = addr_p0;
        Byte   = !is_word_p0;
        SigCtr = is_byte_p0 && sgn_p0 && !we_p0;
        DataIn = is_word_p0 ? wdata_p0 : {24'b0, wdata_p0[7:0]};
        mWR    = we_p0;
        mRD    = !we_p0;
        if (we_p0 || ld_done) state_nxt = is_half_p0 ? ACC1 : RESP;
      end
      ACC1: begin
        DAddr  = addr_p0 + ADDR_W'(1);
        Byte   = 1'b1;
        DataIn = {24'b0, wdata_p0[15:8]};
        mWR    = we_p0;
        mRD    = !we_p0;
        if (we_p0 || ld_done) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      addr_p0   <= '0;
      size_p0   <= '0;
      we_p0     <= 1'b0;
      sgn_p0    <= 1'b0;
      wdata_p0  <= '0;
      rd0_p1    <= '0;
      rd1_p1    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ACC0 || state == ACC1) && !we_p0 && !ld_done) wcnt <= wcnt + CNT_W'(1);
      else                                                        wcnt <= '0;
      // p0: request capture
      if (accept) begin
        addr_p0  <= addr_in;
        size_p0  <= req_size;
        we_p0    <= req_we;
        sgn_p0   <= req_signed;
        wdata_p0 <= req_wdata;
      end
      // p1: read data capture on the last wait cycle of each access
      if (state == ACC0 && !we_p0 && ld_done) rd0_p1 <= DataOut;
      if (state == ACC1 && !we_p0 && ld_done) rd1_p1 <= DataOut[7:0];
      // p2: response
      rsp_valid <= (state == RESP);
      if (state == RESP)
        rsp_rdata <= (we_p0 || err_p0) ? 32'h0 : form_load(size_p0, sgn_p0, rd0_p1, rd1_p1);
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: two instances (WAIT_CYCLES 1 and 3), each on a byte-addressable memory model.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_ready, req_we, req_signed, rsp_valid, rsp_err, busy;
  logic        mRD, mWR, Byte, SigCtr;
  logic [1:0]  req_size;
  logic [11:0] req_addr, DAddr;
  logic [31:0] req_wdata, rsp_rdata, DataIn, DataOut;

  logic        req_valid_b, req_ready_b, req_we_b, req_signed_b, rsp_valid_b, rsp_err_b, busy_b;
  logic        mRD_b, mWR_b, Byte_b, SigCtr_b;
  logic [1:0]  req_size_b;
  logic [11:0] req_addr_b, DAddr_b;
  logic [31:0] req_wdata_b, rsp_rdata_b, DataIn_b, DataOut_b;

  logic [7:0] mem_a [0:4095];
  logic [7:0] mem_b [0:4095];

  lsu_mem_master #(.ADDR_W(12), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mRD(mRD), .mWR(mWR), .Byte(Byte), .SigCtr(SigCtr), .DAddr(DAddr), .DataIn(DataIn),
    .DataOut(DataOut));

  lsu_mem_master #(.ADDR_W(12), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_size(req_size_b), .req_signed(req_signed_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b),
    .mRD(mRD_b), .mWR(mWR_b), .Byte(Byte_b), .SigCtr(SigCtr_b), .DAddr(DAddr_b), .DataIn(DataIn_b),
    .DataOut(DataOut_b));

  // Memory model: combinational little-endian read, byte reads extended by SigCtr, write on rising edge.
  always_comb begin
    if (Byte) DataOut = {{24{SigCtr & mem_a[DAddr][7]}}, mem_a[DAddr]};
    else      DataOut = {mem_a[DAddr+12'd3], mem_a[DAddr+12'd2], mem_a[DAddr+12'd1], mem_a[DAddr]};
    if (Byte_b) DataOut_b = {{24{SigCtr_b & mem_b[DAddr_b][7]}}, mem_b[DAddr_b]};
    else        DataOut_b = {mem_b[DAddr_b+12'd3], mem_b[DAddr_b+12'd2], mem_b[DAddr_b+12'd1], mem_b[DAddr_b]};
  end

  always_ff @(posedge clk) begin
    if (mWR) begin
      if (Byte) mem_a[DAddr] <= DataIn[7:0];
      else begin
        mem_a[DAddr]        <= DataIn[7:0];
        mem_a[DAddr+12'd1]  <= DataIn[15:8];
        mem_a[DAddr+12'd2]  <= DataIn[23:16];
        mem_a[DAddr+12'd3]  <= DataIn[31:24];
      end
    end
    if (mWR_b) begin
      if (Byte_b) mem_b[DAddr_b] <= DataIn_b[7:0];
      else begin
        mem_b[DAddr_b]       <= DataIn_b[7:0];
        mem_b[DAddr_b+12'd1] <= DataIn_b[15:8];
        mem_b[DAddr_b+12'd2] <= DataIn_b[23:16];
        mem_b[DAddr_b+12'd3] <= DataIn_b[31:24];
      end
    end
  end

  int nvec = 0;
  int nmis = 0;

  // Results of the last do_req transaction on the WAIT_CYCLES=1 instance.
  int          r_lat, r_nwr, r_nrd;
  logic [31:0] r_rdata, r_dw0;
  logic [11:0] r_a0, r_a1;
  logic [7:0]  r_d1;
  logic        r_err, r_byte, r_sig;

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [11:0] addr, input logic [31:0] wdata);
    int   g;
    logic done;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    r_lat = 0; r_nwr = 0; r_nrd = 0; r_a0 = '0; r_a1 = '0; r_dw0 = '0; r_d1 = '0;
    r_byte = 1'b0; r_sig = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) done = 1'b1;
      else begin
        if (mWR || mRD) begin
          if (r_nwr + r_nrd == 0) begin r_a0 = DAddr; r_dw0 = DataIn; end
          else begin r_a1 = DAddr; r_d1 = DataIn[7:0]; end
          r_byte = r_byte | Byte;
          r_sig  = r_sig | SigCtr;
          if (mWR) r_nwr++;
          if (mRD) r_nrd++;
        end
        r_lat++;
      end
    end
    if (!done) r_lat = -1;
    r_rdata = rsp_rdata;
    r_err   = rsp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (req_ready !== 1'b1) begin nmis++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    nvec++; if ({rsp_valid, rsp_err, busy, mRD, mWR, Byte, SigCtr} !== 7'b0) begin nmis++;
      $display("FAIL rst_flags got=%b want=0000000", {rsp_valid, rsp_err, busy, mRD, mWR, Byte, SigCtr}); end
    nvec++; if ({DAddr, DataIn, rsp_rdata} !== 76'h0) begin nmis++;
      $display("FAIL rst_buses daddr=%h datain=%h rdata=%h want 0", DAddr, DataIn, rsp_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
    nvec++; if (r_lat !== 2) begin nmis++; $display("FAIL wst_lat got=%0d want=2", r_lat); end
    nvec++; if (r_nwr !== 1 || r_nrd !== 0) begin nmis++; $display("FAIL wst_strobes wr=%0d rd=%0d want 1/0", r_nwr, r_nrd); end
    nvec++; if (r_a0 !== 12'h010 || r_dw0 !== 32'hDEADBEEF || r_byte !== 1'b0) begin nmis++;
      $display("FAIL wst_bus addr=%h data=%h byte=%b want 010/deadbeef/0", r_a0, r_dw0, r_byte); end
    nvec++; if (r_rdata !== 32'h0) begin nmis++; $display("FAIL wst_rdata got=%h want=0", r_rdata); end
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    nvec++; if (r_lat !== 2) begin nmis++; $display("FAIL wld_lat got=%0d want=2", r_lat); end
    nvec++; if (r_nrd !== 1 || r_nwr !== 0) begin nmis++; $display("FAIL wld_strobes rd=%0d wr=%0d want 1/0", r_nrd, r_nwr); end
    nvec++; if (r_rdata !== 32'hDEADBEEF) begin nmis++; $display("FAIL wld_rdata got=%h want=deadbeef", r_rdata); end
    @(negedge clk);
    nvec++; if (rsp_valid !== 1'b0) begin nmis++; $display("FAIL rsp_pulse got=%b want=0", rsp_valid); end
    nvec++; if (rsp_rdata !== 32'hDEADBEEF) begin nmis++; $display("FAIL rdata_hold got=%h want=deadbeef", rsp_rdata); end
  endtask

  task automatic test_byte();
    do_req(1'b1, 2'b00, 1'b0, 12'h013, 32'h12345680);
    nvec++; if (r_lat !== 2 || r_nwr !== 1) begin nmis++; $display("FAIL bst_lat lat=%0d wr=%0d want 2/1", r_lat, r_nwr); end
    nvec++; if (r_a0 !== 12'h013 || r_dw0 !== 32'h00000080 || r_byte !== 1'b1) begin nmis++;
      $display("FAIL bst_bus addr=%h data=%h byte=%b want 013/00000080/1", r_a0, r_dw0, r_byte); end
    do_req(1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    nvec++; if (r_rdata !== 32'hFFFFFF80) begin nmis++; $display("FAIL bld_s_rdata got=%h want=ffffff80", r_rdata); end
    nvec++; if (r_a0 !== 12'h013 || r_byte !== 1'b1 || r_sig !== 1'b1 || r_lat !== 2) begin nmis++;
      $display("FAIL bld_s_bus addr=%h byte=%b sig=%b lat=%0d want 013/1/1/2", r_a0, r_byte, r_sig, r_lat); end
    do_req(1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
    nvec++; if (r_rdata !== 32'h00000080 || r_sig !== 1'b0) begin nmis++;
      $display("FAIL bld_u rdata=%h sig=%b want 00000080/0", r_rdata, r_sig); end
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    nvec++; if (r_rdata !== 32'h80ADBEEF) begin nmis++; $display("FAIL bld_word got=%h want=80adbeef", r_rdata); end
  endtask

  task automatic test_half();
    do_req(1'b1, 2'b10, 1'b0, 12'h020, 32'h55667788);
    do_req(1'b1, 2'b01, 1'b0, 12'h020, 32'hABCD1234);
    nvec++; if (r_lat !== 3 || r_nwr !== 2) begin nmis++; $display("FAIL hst_lat lat=%0d wr=%0d want 3/2", r_lat, r_nwr); end
    nvec++; if (r_a0 !== 12'h020 || r_dw0[7:0] !== 8'h34 || r_a1 !== 12'h021 || r_d1 !== 8'h12 || r_byte !== 1'b1) begin nmis++;
      $display("FAIL hst_bus a0=%h d0=%h a1=%h d1=%h byte=%b want 020/34/021/12/1", r_a0, r_dw0[7:0], r_a1, r_d1, r_byte); end
    do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    nvec++; if (r_rdata !== 32'h55661234) begin nmis++; $display("FAIL hst_word got=%h want=55661234", r_rdata); end
    do_req(1'b1, 2'b01, 1'b0, 12'h024, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b1, 12'h024, 32'h0);
    nvec++; if (r_rdata !== 32'hFFFF8001) begin nmis++; $display("FAIL hld_s_rdata got=%h want=ffff8001", r_rdata); end
    nvec++; if (r_lat !== 3 || r_nrd !== 2 || r_sig !== 1'b0 || r_a1 !== 12'h025) begin nmis++;
      $display("FAIL hld_s_bus lat=%0d rd=%0d sig=%b a1=%h want 3/2/0/025", r_lat, r_nrd, r_sig, r_a1); end
    do_req(1'b0, 2'b01, 1'b0, 12'h024, 32'h0);
    nvec++; if (r_rdata !== 32'h00008001) begin nmis++; $display("FAIL hld_u_rdata got=%h want=00008001", r_rdata); end
  endtask

  task automatic test_misalign();
    do_req(1'b0, 2'b10, 1'b0, 12'h022, 32'h0);
`ifdef MISALIGN_TRAP_EN
    nvec++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin nmis++; $display("FAIL mis_err err=%b rdata=%h want 1/0", r_err, r_rdata); end
    nvec++; if (r_lat !== 1 || r_nrd !== 0) begin nmis++; $display("FAIL mis_lat lat=%0d rd=%0d want 1/0", r_lat, r_nrd); end
    @(negedge clk);
    nvec++; if (rsp_err !== 1'b0) begin nmis++; $display("FAIL mis_err_pulse got=%b want=0", rsp_err); end
    do_req(1'b0, 2'b01, 1'b0, 12'h025, 32'h0);
    nvec++; if (r_err !== 1'b1 || r_nrd !== 0) begin nmis++; $display("FAIL mis_half err=%b rd=%0d want 1/0", r_err, r_nrd); end
`else
    nvec++; if (r_a0 !== 12'h020 || r_rdata !== 32'h55661234) begin nmis++;
      $display("FAIL mis_align addr=%h rdata=%h want 020/55661234", r_a0, r_rdata); end
    nvec++; if (r_err !== 1'b0 || r_lat !== 2) begin nmis++; $display("FAIL mis_noerr err=%b lat=%0d want 0/2", r_err, r_lat); end
    do_req(1'b0, 2'b01, 1'b0, 12'h025, 32'h0);
    nvec++; if (r_a0 !== 12'h024 || r_rdata !== 32'h00008001) begin nmis++;
      $display("FAIL mis_half addr=%h rdata=%h want 024/00008001", r_a0, r_rdata); end
`endif
  endtask

  task automatic test_reset_abort();
    logic saw;
    do_req(1'b1, 2'b10, 1'b0, 12'h030, 32'h5A5A5A5A);
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 12'h030; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    nvec++; if (mWR !== 1'b1) begin nmis++; $display("FAIL abort_pre_mwr got=%b want=1", mWR); end
    rst_n = 1'b0;
    #1;
    nvec++; if (mWR !== 1'b0 || busy !== 1'b0) begin nmis++; $display("FAIL abort_mwr mwr=%b busy=%b want 0/0", mWR, busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid) saw = 1'b1; end
    nvec++; if (saw !== 1'b0 || req_ready !== 1'b1) begin nmis++; $display("FAIL abort_rsp saw=%b ready=%b want 0/1", saw, req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 12'h030, 32'h0);
    nvec++; if (r_rdata !== 32'h5A5A5A5A) begin nmis++; $display("FAIL abort_mem got=%h want=5a5a5a5a", r_rdata); end
  endtask

  task automatic test_back_to_back();
    logic        t_we [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_sz [4]  = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic        t_sg [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [11:0] t_ad [4]  = '{12'h040, 12'h042, 12'h040, 12'h042};
    logic [31:0] t_wd [4]  = '{32'h000000C3, 32'h0000A55A, 32'h0, 32'h0};
    int          t_lat [4] = '{2, 3, 4, 7};
    logic [31:0] t_rd [4]  = '{32'h0, 32'h0, 32'hFFFFFFC3, 32'hFFFFA55A};
    int   lat;
    logic done, bad;
    req_valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_we_b = t_we[i]; req_size_b = t_sz[i]; req_signed_b = t_sg[i];
      req_addr_b = t_ad[i]; req_wdata_b = t_wd[i];
      @(posedge clk);
      lat = 0; done = 1'b0; bad = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
        @(negedge clk);
        if (rsp_valid_b) done = 1'b1;
        else begin
          if (req_ready_b || !busy_b) bad = 1'b1;
          lat++;
        end
      end
      if (!done) lat = -1;
      nvec++; if (lat !== t_lat[i]) begin nmis++; $display("FAIL b2b_lat[%0d] got=%0d want=%0d", i, lat, t_lat[i]); end
      nvec++; if (rsp_rdata_b !== t_rd[i]) begin nmis++; $display("FAIL b2b_rdata[%0d] got=%h want=%h", i, rsp_rdata_b, t_rd[i]); end
      nvec++; if (bad !== 1'b0) begin nmis++; $display("FAIL b2b_ready[%0d] ready high while busy got=%b want=0", i, bad); end
    end
    req_valid_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_size_b = 2'b00; req_signed_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
